// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its multiply/divide unit.
// Contents: operation codes (alu_op_e), mult/div sequencer states
// (muldiv_state_e) and the operation-select width.
package alu_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_SLTU  = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011,
    OP_MFHI  = 4'b1100,
    OP_MFLO  = 4'b1101,
    OP_MTHI  = 4'b1110,
    OP_MTLO  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with the architectural HI/LO registers.
//
// state  | meaning
// IDLE   | waiting; accepts mult/div launch or mthi/mtlo on start
// RUN    | one shift-add / shift-subtract step per cycle, then one
//        | cycle (cnt == DATA_WIDTH) that writes the corrected result
// FINISH | HI/LO hold the new result, done pulses, busy still high
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   srca, srcb            - operands (dividend/multiplicand, divisor/multiplier)
//   alu_control, start    - operation select and one-cycle launch strobe
//   busy, done            - in-progress flag, one-cycle completion pulse
//   hi, lo                - architectural HI/LO registers
//
// Build option: ALU_DIV_EN builds the divider; without it div/divu
// launches are ignored.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     srca,
  input  logic [DATA_WIDTH-1:0]     srcb,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     hi,
  output logic [DATA_WIDTH-1:0]     lo
);

  localparam int W         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH);

  muldiv_state_e        state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         acc_hi;
  logic [W-1:0]         acc_lo;
  logic [W-1:0]         opb;
  logic                 neg_q;

  logic                 launch;
  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [W-1:0]         a_mag;
  logic [W-1:0]         b_mag;
  logic [W:0]           mul_sum;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         step_hi;
  logic [W-1:0]         step_lo;
  logic [W-1:0]         fin_hi;
  logic [W-1:0]         fin_lo;

`ifdef ALU_DIV_EN
  logic                 launch_div;
  logic                 is_div;
  logic                 neg_r;
  logic                 dbz;
  logic [W:0]           div_shift;
  logic [W-1:0]         div_diff;
  logic [W-1:0]         quo;
  logic [W-1:0]         rem;
`endif

  always_comb begin
    launch    = 1'b0;
    signed_op = 1'b0;
`ifdef ALU_DIV_EN
    launch_div = 1'b0;
`endif
    case (alu_op_e'(alu_control))
      OP_MULT: begin
        launch    = 1'b1;
        signed_op = 1'b1;
      end
      OP_MULTU: launch = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        launch     = 1'b1;
        launch_div = 1'b1;
        signed_op  = 1'b1;
      end
      OP_DIVU: begin
        launch     = 1'b1;
        launch_div = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Both algorithms run on magnitudes; the most-negative value still fits
  // as an unsigned W-bit magnitude.
  always_comb begin
    a_neg = signed_op & srca[W-1];
    b_neg = signed_op & srcb[W-1];
    a_mag = a_neg ? (~srca + 1'b1) : srca;
    b_mag = b_neg ? (~srcb + 1'b1) : srcb;
  end

  always_comb begin
    // Shift-add multiply: acc_hi:acc_lo is the partial product with the
    // multiplier shifting out of the bottom of acc_lo.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
    step_hi = mul_sum[W:1];
    step_lo = {mul_sum[0], acc_lo[W-1:1]};

    prod   = {acc_hi, acc_lo};
    if (neg_q) prod = ~prod + 1'b1;
    fin_hi = prod[2*W-1:W];
    fin_lo = prod[W-1:0];

`ifdef ALU_DIV_EN
    // Restoring divide: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out of its top while quotient bits enter at the bottom.
    // A zero divisor always "subtracts", giving an all-ones quotient and
    // the dividend magnitude as remainder.
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift[W-1:0] - opb;
    quo       = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    rem       = neg_r ? (~acc_hi + 1'b1) : acc_hi;
    if (is_div) begin
      if (div_shift >= {1'b0, opb}) begin
        step_hi = div_diff;
        step_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b0};
      end
      fin_hi = rem;
      fin_lo = dbz ? {W{1'b1}} : quo;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
`ifdef ALU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (launch) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= a_mag;
              opb    <= b_mag;
              neg_q  <= a_neg ^ b_neg;
`ifdef ALU_DIV_EN
              is_div <= launch_div;
              neg_r  <= a_neg;
              dbz    <= (srcb == '0);
`endif
            end else if (alu_op_e'(alu_control) == OP_MTHI) begin
              hi <= srca;
            end else if (alu_op_e'(alu_control) == OP_MTLO) begin
              lo <= srca;
            end
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            hi    <= fin_hi;
            lo    <= fin_lo;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational add/sub/logic/compare plus mfhi/mflo,
// backed by an iterative multiply/divide unit (muldiv_seq) owning HI/LO.
//
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   srca, srcb         - operands
//   alu_control        - operation select (alu_pkg::alu_op_e)
//   start              - launch mult/div or mthi/mtlo
//   alu_result, zero   - combinational result and result==0 flag
//   busy, done         - mult/div in progress, completion pulse
//   hi, lo             - HI/LO registers
//
// Build option: define ALU_DIV_EN to include the divider.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     srca,
  input  logic [DATA_WIDTH-1:0]     srcb,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_control,
  input  logic                      start,
  output logic [DATA_WIDTH-1:0]     alu_result,
  output logic                      zero,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     hi,
  output logic [DATA_WIDTH-1:0]     lo
);

  muldiv_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv_seq (
    .clk         (clk),
    .reset       (reset),
    .srca        (srca),
    .srcb        (srcb),
    .alu_control (alu_control),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(alu_control))
      OP_ADD:  alu_result = srca + srcb;
      OP_SUB:  alu_result = srca - srcb;
      OP_AND:  alu_result = srca & srcb;
      OP_OR:   alu_result = srca | srcb;
      OP_XOR:  alu_result = srca ^ srcb;
      OP_NOR:  alu_result = ~(srca | srcb);
      OP_SLT:  alu_result[0] = ($signed(srca) < $signed(srcb));
      OP_SLTU: alu_result[0] = (srca < srcb);
      // HI/LO reads see the architectural value, which only changes when
      // a mult/div completes, so reads while busy return the old result.
      OP_MFHI: alu_result = hi;
      OP_MFLO: alu_result = lo;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic [3:0]   alu_control = '0;
  logic         start = 1'b0;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_muldiv #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .srca        (srca),
    .srcb        (srcb),
    .alu_control (alu_control),
    .start       (start),
    .alu_result  (alu_result),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Architectural HI/LO as the model sees them.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] comb_ref(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0100: return ~(a | b);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b0101: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return m_hi;
      4'b1101: return m_lo;
      default: return '0;
    endcase
  endfunction

  function automatic exp_t md_ref(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    e.done_cyc = 0;
    e.hi = '0;
    e.lo = '0;
    if (op == 4'b1000 || op == 4'b1010) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    if (op == 4'b1000 || op == 4'b1001) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("md_hi", hi, e.hi);
        chk("md_lo", lo, e.lo);
        chk("done_cycle", cyc, e.done_cyc);
        m_hi = e.hi;
        m_lo = e.lo;
      end
    end
  end

  task automatic run_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit probe);
    exp_t e;
    int   n;
    e = md_ref(op, a, b);
    @(negedge clk);
    srca = a;
    srcb = b;
    alu_control = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    e.done_cyc = n + W + 1;
    sb_q.push_back(e);
    chk("busy_after_launch", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    if (probe) begin
      repeat (4) @(negedge clk);
      alu_control = 4'b1100;
      #1;
      chk("mfhi_while_busy", alu_result, m_hi);
      alu_control = 4'b1111;
      srca = 32'h0000_00AA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < W + 10; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_clear", busy, 1'b0);
    chk("busy_fall_cycle", cyc, n + W + 2);
    chk("done_seen", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    // Directed combinational cases.
    @(negedge clk);
    srca = 32'h7FFF_FFFF; srcb = 32'h1; alu_control = 4'b0010; #1;
    chk("add_wrap", alu_result, 32'h8000_0000);
    chk("add_zero_flag", zero, 1'b0);
    srca = 5; srcb = 5; alu_control = 4'b0110; #1;
    chk("sub_result", alu_result, 0);
    chk("sub_zero_flag", zero, 1'b1);
    srca = 32'hFFFF_FFFF; srcb = 1; alu_control = 4'b0111; #1;
    chk("slt_neg", alu_result, 1);
    alu_control = 4'b0101; #1;
    chk("sltu_big", alu_result, 0);

    // mthi / mtlo while idle; a non-sequential code with start does nothing.
    @(negedge clk);
    srca = 32'h1234_5678; alu_control = 4'b1110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; m_hi = 32'h1234_5678;
    chk("mthi", hi, m_hi);
    @(negedge clk);
    srca = 32'h9ABC_DEF0; alu_control = 4'b1111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; m_lo = 32'h9ABC_DEF0;
    chk("mtlo", lo, m_lo);
    @(negedge clk);
    srca = 3; srcb = 4; alu_control = 4'b0010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_nonseq_ignored", busy, 1'b0);
    alu_control = 4'b1101; #1;
    chk("mflo", alu_result, m_lo);

    // Multiply with mid-run probes, then unsigned with the same operands.
    run_md(4'b1000, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    run_md(4'b1001, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("multu_hi", hi, 32'h4);
    chk("multu_lo", lo, 32'hFFFF_FFF1);

`ifdef ALU_DIV_EN
    run_md(4'b1011, 32'd100, 32'd7, 1'b0);
    chk("divu_q", lo, 14);
    chk("divu_r", hi, 2);
    run_md(4'b1010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_q", lo, 32'hFFFF_FFFD);
    chk("div_neg_r", hi, 32'hFFFF_FFFF);
    run_md(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_q", lo, 32'h8000_0000);
    chk("div_ovf_r", hi, 0);
    run_md(4'b1010, 32'd123, 32'd0, 1'b1);
    chk("div0_q", lo, 32'hFFFF_FFFF);
    chk("div0_r", hi, 123);
`else
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      srca = 100; srcb = 7; alu_control = 4'b1011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (busy || done) seen = 1'b1;
      repeat (W + 4) begin
        @(negedge clk);
        if (busy || done) seen = 1'b1;
      end
      chk("divu_disabled_no_busy", seen, 1'b0);
      chk("divu_disabled_hi", hi, m_hi);
      chk("divu_disabled_lo", lo, m_lo);
    end
`endif

    // Reset in the middle of a multiply aborts it without a HI/LO update.
    @(negedge clk);
    srca = 6; srcb = 7; alu_control = 4'b1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 5) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    run_md(4'b1000, 32'd6, 32'd7, 1'b0);
    chk("mult_6x7_lo", lo, 42);
    chk("mult_6x7_hi", hi, 0);

    // Randomized mult (and div when built) against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
`ifdef ALU_DIV_EN
      op = 4'($urandom_range(8, 11));
`else
      op = 4'($urandom_range(8, 9));
`endif
      run_md(op, rand_val(), rand_val(), 1'b0);
    end

    // Randomized single-cycle operations (start low, so no side effects).
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      op = 4'($urandom_range(0, 15));
      a = rand_val();
      b = rand_val();
      r = comb_ref(op, a, b);
      @(negedge clk);
      srca = a; srcb = b; alu_control = op; start = 1'b0;
      #1;
      chk("rand_comb_result", alu_result, r);
      chk("rand_comb_zero", zero, (r == '0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational add/sub/and/or path.
- Adds xor, nor, slt and sltu.
- Adds an iterative multi-cycle multiply/divide unit with architectural HI/LO registers, MIPS-style.
- Sits in the execute stage. The control unit stalls the pipeline while busy is high.

Parameters:
DATA_WIDTH, 32, operand/result/HI/LO width; even and >= 4.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
srca  input  DATA_WIDTH  operand A.
srcb  input  DATA_WIDTH  operand B.
alu_control  input  4  operation select.
start  input  1  one-cycle request to launch mult/multu/div/divu or to write HI/LO.
alu_result  output  DATA_WIDTH  combinational result.
zero  output  1  high when alu_result == 0.
busy  output  1  high while a mult/div is in progress.
done  output  1  one-cycle pulse when HI/LO take the mult/div result.
hi  output  DATA_WIDTH  HI register.
lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset: asynchronous, active-high; the polarity and synchronicity are fixed. reset high clears hi, lo, busy, done, the counter and all internal registers to 0 and sets state IDLE. Reset aborts any operation in flight with no HI/LO update.
- Encoding, combinational, valid every cycle:
  - 0010 add; 0110 sub; 0000 and; 0001 or.
  - 0011 xor; 0100 nor.
  - 0111 slt (signed, result 1 or 0); 0101 sltu (unsigned).
  - 1100 mfhi (result = hi); 1101 mflo (result = lo).
  - Add/sub wrap modulo 2^DATA_WIDTH. No overflow flag.
- Sequential codes, take effect only when start=1:
  - 1000 mult, 1001 multu, 1010 div, 1011 divu.
  - 1110 mthi (hi<=srca next edge); 1111 mtlo (lo<=srca next edge).
- alu_result for the sequential codes, and for any undefined code: 0.
- mfhi/mflo while busy return the current, old HI/LO.
- FSM states IDLE, RUN, FINISH:
  - IDLE + start + mult/div code: latch operand magnitudes and result signs. Go to RUN with counter=0 and busy=1 from the next cycle.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle for DATA_WIDTH cycles, then go to FINISH.
  - FINISH: apply sign correction and write HI/LO. done=1 for this cycle only. busy stays 1. Next state IDLE.
- Latency: start sampled at edge N. done and the HI/LO update occur in cycle N+DATA_WIDTH+1. busy deasserts at edge N+DATA_WIDTH+2.
- Result format:
  - mult/multu: {hi,lo} = full 2*DATA_WIDTH product.
  - div/divu: lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
- Divide by zero: runs the full latency. Result lo = all ones, hi = srca.
- Signed most-negative / -1: lo = most-negative, hi = 0.
- start while busy: ignored, including mthi/mtlo. No queueing.
- start with any non-sequential code: ignored.

Optional Feature:
ALU_DIV_EN
- Defined: div/divu implemented as above.
- Undefined: divider datapath not built. start with 1010/1011 is ignored: no busy, no done, HI/LO unchanged. Multiply and all other behaviour are identical.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e enum with the 4-bit codes above;
  - muldiv_state_e enum {IDLE, RUN, FINISH};
  - constant ALU_CTRL_WIDTH = 4.
- One sub-module, muldiv_seq, holds the FSM, counter, shift registers and HI/LO.
- Top-level alu_muldiv holds the combinational ALU, the result mux and zero.

Test Plan:
- After reset, add 0x7FFFFFFF + 1 -> alu_result=0x80000000, zero=0. Then sub 5-5 -> alu_result=0, zero=1. Then slt 0xFFFFFFFF,1 -> 1; sltu same operands -> 0.
- mult srca=0xFFFFFFFD (-3), srcb=5, start at edge N -> busy edges N+1..N+33, done only in cycle N+33. Then hi=0xFFFFFFFF, lo=0xFFFFFFF1; multu same operands -> hi=0x4, lo=0xFFFFFFF1.
- divu 100/7 -> lo=14, hi=2. div 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- div 123/0 -> full latency, then lo=0xFFFFFFFF, hi=123. mtlo 0xAA while busy -> ignored. mfhi during RUN -> old hi.
- Start mult 6*7, assert reset at cycle N+10 -> hi=lo=0, busy=0, no done pulse. Then mult 6*7 -> lo=42, hi=0.
- Build without ALU_DIV_EN: divu 100/7 with start -> busy never asserts, HI/LO unchanged. mult still correct.
